// File: rtl/memctrl_bus_pkg.sv
// Shared definitions for the memory/IO bus controller: port offsets,
// STATUS bit positions, PS/2 codes and the port decoder.
package memctrl_bus_pkg;

    // Port offsets relative to IO_BASE
    localparam logic [15:0] OFF_BANK   = 16'h0000;
    localparam logic [15:0] OFF_KEYB   = 16'h0001;
    localparam logic [15:0] OFF_STATUS = 16'h0002;
    localparam logic [15:0] OFF_KCTRL  = 16'h0003;
    localparam logic [15:0] OFF_CURSX  = 16'h000C;
    localparam logic [15:0] OFF_CURSY  = 16'h000D;
    localparam logic [15:0] OFF_VIDEO  = 16'h0018;

    // STATUS register layout: {full, overflow, empty, 0, count[3:0]}
    localparam int ST_FULL  = 7;
    localparam int ST_OVF   = 6;
    localparam int ST_EMPTY = 5;

    // KCTRL command bits
    localparam int KCTRL_FLUSH   = 0;
    localparam int KCTRL_CLR_OVF = 1;

    // PS/2 set-2 scancodes of interest
    localparam logic [7:0] PS2_RELEASE = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT  = 8'h12;
    localparam logic [7:0] PS2_RSHIFT  = 8'h59;

    typedef enum logic [2:0] {
        PORT_NONE,
        PORT_BANK,
        PORT_KEYB,
        PORT_STATUS,
        PORT_KCTRL,
        PORT_CURSX,
        PORT_CURSY,
        PORT_VIDEO
    } port_e;

    // Map an offset from IO_BASE to the register it selects
    function automatic port_e decode_port(input logic [15:0] off);
        case (off)
            OFF_BANK:   return PORT_BANK;
            OFF_KEYB:   return PORT_KEYB;
            OFF_STATUS: return PORT_STATUS;
            OFF_KCTRL:  return PORT_KCTRL;
            OFF_CURSX:  return PORT_CURSX;
            OFF_CURSY:  return PORT_CURSY;
            OFF_VIDEO:  return PORT_VIDEO;
            default:    return PORT_NONE;
        endcase
    endfunction

    // STATUS only has a 4-bit count field; a 16-deep FIFO saturates at 15
    function automatic logic [3:0] sat_count(input logic [4:0] c);
        return (c > 5'd15) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/memctrl_bus_fifo.sv
// Keyboard byte FIFO: power-of-two depth, wrapping pointers, occupancy
// count one bit wider than the pointers. Flush beats a same-cycle push.
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd];

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot
    assign w_pop  = pop && !empty && !flush;
    assign w_push = push && !flush && (!full || w_pop);

    // Byte storage
    // NOTE: storage carries no reset; valid data is defined by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= wdata;
    end

    // Pointer and occupancy tracking
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/memctrl_bus.sv
// CPU bus controller: banked device window, SRAM pass-through, and a small
// port block holding bank/video registers and a PS/2 keyboard FIFO.
module memctrl_bus
    import memctrl_bus_pkg::*;
#(
    parameter logic [15:0] WIN_BASE = 16'hF000,
    parameter logic [15:0] IO_BASE  = 16'h0020,
    parameter int          NDEV     = 2,
    parameter int          KDEPTH   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       address,
    input  logic              wren,
    input  logic              rden,
    input  logic [7:0]        data_o,
    output logic [7:0]        data_i,
    input  logic [7:0]        data_o_sram,
    output logic              data_w_sram,
    input  logic [8*NDEV-1:0] dev_rdata,
    output logic [NDEV-1:0]   dev_we,
    output logic [7:0]        bank,
    output logic [7:0]        cursor_x,
    output logic [7:0]        cursor_y,
    output logic [7:0]        videomode,
    input  logic [7:0]        ps2_data,
    input  logic              ps2_hit,
    input  logic [6:0]        kb_ascii,
    output logic              kb_shift
);
    localparam int CW = $clog2(KDEPTH) + 1;

    logic [7:0]    r_bank, r_cursx, r_cursy, r_video;
    logic          r_release, r_kb_shift, r_ovf;

    logic          w_in_win;
    logic [3:0]    w_sel;
    logic [15:0]   w_off;
    port_e         w_port;
    logic          w_kctrl_wr, w_flush, w_pop, w_kb_push, w_ovf_set;
    logic [7:0]    w_head, w_status;
    logic [CW-1:0] w_count;
    logic          w_full, w_empty;

    assign w_in_win = (address >= WIN_BASE);
    assign w_sel    = r_bank[7:4];
    assign w_off    = address - IO_BASE;
    assign w_port   = (!w_in_win && address >= IO_BASE) ? decode_port(w_off) : PORT_NONE;

    // Port addresses never reach SRAM, even the read-only ones
    assign data_w_sram = wren && !w_in_win && (w_port == PORT_NONE);

    assign w_kctrl_wr = wren && (w_port == PORT_KCTRL);
    assign w_flush    = w_kctrl_wr && data_o[KCTRL_FLUSH];
    assign w_pop      = rden && (w_port == PORT_KEYB);
    assign w_kb_push  = ps2_hit && (ps2_data != PS2_RELEASE);
    // Full implies non-empty, so a requested pop always frees the slot
    assign w_ovf_set  = w_kb_push && w_full && !w_pop && !w_flush;

    kbd_fifo #(.DEPTH(KDEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_kb_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata ({r_release, kb_ascii}),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Assemble STATUS from the FIFO flags and sticky overflow
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_status           = '0;
        w_status[ST_FULL]  = w_full;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_EMPTY] = w_empty;
        w_status[3:0]      = sat_count(5'(w_count));
    end

    // Per-device write enables inside the banked window
    always_comb begin
        dev_we = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (w_in_win && int'(w_sel) == i + 1) dev_we[i] = wren;
        end
    end

    // CPU read data mux: window, port registers, else SRAM
    always_comb begin
        data_i = data_o_sram;
        if (w_in_win) begin
            data_i = 8'hFF;
            for (int i = 0; i < NDEV; i++) begin
                if (int'(w_sel) == i + 1) data_i = dev_rdata[i*8 +: 8];
            end
        end else begin
            case (w_port)
                PORT_BANK:   data_i = r_bank;
                PORT_KEYB:   data_i = w_empty ? 8'h00 : w_head;
                PORT_STATUS: data_i = w_status;
                PORT_CURSX:  data_i = r_cursx;
                PORT_CURSY:  data_i = r_cursy;
                PORT_VIDEO:  data_i = r_video;
                default:     ;
            endcase
        end
    end

    // Writable port registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bank  <= '0;
            r_cursx <= '0;
            r_cursy <= '0;
            r_video <= '0;
        end else if (wren) begin
            case (w_port)
                PORT_BANK:  r_bank  <= data_o;
                PORT_CURSX: r_cursx <= data_o;
                PORT_CURSY: r_cursy <= data_o;
                PORT_VIDEO: r_video <= data_o;
                default:    ;
            endcase
        end
    end

    // PS/2 release-prefix tracking and shift state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_release  <= 1'b0;
            r_kb_shift <= 1'b0;
        end else if (ps2_hit) begin
            if (ps2_data == PS2_RELEASE) begin
                r_release <= 1'b1;
            end else begin
                r_release <= 1'b0;
                if (ps2_data == PS2_LSHIFT || ps2_data == PS2_RSHIFT) r_kb_shift <= ~r_release;
            end
        end
    end

    // Sticky overflow: a dropped byte wins over a same-cycle clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                   r_ovf <= 1'b0;
        else if (w_ovf_set)                          r_ovf <= 1'b1;
        else if (w_kctrl_wr && data_o[KCTRL_CLR_OVF]) r_ovf <= 1'b0;
    end

    assign bank      = r_bank;
    assign cursor_x  = r_cursx;
    assign cursor_y  = r_cursy;
    assign videomode = r_video;
    assign kb_shift  = r_kb_shift;

endmodule

// File: tb/tb_memctrl_bus.sv
// Self-checking bench for memctrl_bus: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_memctrl_bus;
    localparam logic [15:0] WIN = 16'hF000;
    localparam logic [15:0] IOB = 16'h0020;
    localparam int          ND  = 2;
    localparam int          KD  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [15:0]       address;
    logic              wren, rden;
    logic [7:0]        data_o, data_i, data_o_sram;
    logic              data_w_sram;
    logic [8*ND-1:0]   dev_rdata;
    logic [ND-1:0]     dev_we;
    logic [7:0]        bank, cursor_x, cursor_y, videomode;
    logic [7:0]        ps2_data;
    logic              ps2_hit;
    logic [6:0]        kb_ascii;
    logic              kb_shift;

    memctrl_bus #(.WIN_BASE(WIN), .IO_BASE(IOB), .NDEV(ND), .KDEPTH(KD)) dut (
        .clock(clock), .reset(reset), .address(address), .wren(wren), .rden(rden),
        .data_o(data_o), .data_i(data_i), .data_o_sram(data_o_sram),
        .data_w_sram(data_w_sram), .dev_rdata(dev_rdata), .dev_we(dev_we),
        .bank(bank), .cursor_x(cursor_x), .cursor_y(cursor_y), .videomode(videomode),
        .ps2_data(ps2_data), .ps2_hit(ps2_hit), .kb_ascii(kb_ascii), .kb_shift(kb_shift)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_bank, m_cx, m_cy, m_vid;
    logic       m_rel, m_shift, m_ovf;
    logic [7:0] m_q[$];

    task automatic model_reset();
        m_bank = 0; m_cx = 0; m_cy = 0; m_vid = 0;
        m_rel = 0; m_shift = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // -2: banked window, -1: plain SRAM, otherwise the decoded port offset
    function automatic int port_of(input logic [15:0] a);
        logic [15:0] off;
        if (a >= WIN) return -2;
        if (a < IOB)  return -1;
        off = a - IOB;
        case (off)
            16'h0, 16'h1, 16'h2, 16'h3, 16'hC, 16'hD, 16'h18: return int'(off);
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] exp_status();
        int n = m_q.size();
        logic [3:0] c = (n > 15) ? 4'hF : 4'(n);
        return {(n == KD), m_ovf, (n == 0), 1'b0, c};
    endfunction

    function automatic logic [7:0] exp_data_i();
        int p   = port_of(address);
        int sel = int'(m_bank[7:4]);
        if (p == -2) return (sel >= 1 && sel <= ND) ? dev_rdata[(sel-1)*8 +: 8] : 8'hFF;
        case (p)
            0:  return m_bank;
            1:  return (m_q.size() > 0) ? m_q[0] : 8'h00;
            2:  return exp_status();
            12: return m_cx;
            13: return m_cy;
            24: return m_vid;
            default: return data_o_sram;
        endcase
    endfunction

    function automatic logic [ND-1:0] exp_dev_we();
        int sel = int'(m_bank[7:4]);
        logic [ND-1:0] v = '0;
        if (port_of(address) == -2 && wren && sel >= 1 && sel <= ND) v[sel-1] = 1'b1;
        return v;
    endfunction

    task automatic check_model();
        check("data_i",      data_i,      exp_data_i());
        check("data_w_sram", data_w_sram, wren && port_of(address) == -1);
        check("dev_we",      dev_we,      exp_dev_we());
        check("bank",        bank,        m_bank);
        check("cursor_x",    cursor_x,    m_cx);
        check("cursor_y",    cursor_y,    m_cy);
        check("videomode",   videomode,   m_vid);
        check("kb_shift",    kb_shift,    m_shift);
    endtask

    task automatic model_step();
        int  p = port_of(address);
        bit  flush = 0, clr = 0, pop_ok, was_full, ovf_set = 0;
        was_full = (m_q.size() == KD);
        if (wren) begin
            case (p)
                0:  m_bank = data_o;
                3:  begin flush = data_o[0]; clr = data_o[1]; end
                12: m_cx = data_o;
                13: m_cy = data_o;
                24: m_vid = data_o;
                default: ;
            endcase
        end
        pop_ok = rden && p == 1 && m_q.size() > 0 && !flush;
        if (flush) m_q.delete();
        else if (pop_ok) void'(m_q.pop_front());
        if (ps2_hit) begin
            if (ps2_data == 8'hF0) begin
                m_rel = 1;
            end else begin
                if (!flush) begin
                    if (was_full && !pop_ok) ovf_set = 1;
                    else m_q.push_back({m_rel, kb_ascii});
                end
                if (ps2_data == 8'h12 || ps2_data == 8'h59) m_shift = ~m_rel;
                m_rel = 0;
            end
        end
        m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; inputs settle for 1 time unit before any check
    task automatic set_in(input logic [15:0] a, input logic w, input logic r, input logic [7:0] d,
                          input logic h, input logic [7:0] code, input logic [6:0] asc);
        address = a; wren = w; rden = r; data_o = d;
        ps2_hit = h; ps2_data = code; kb_ascii = asc;
        data_o_sram = 8'($urandom());
        for (int i = 0; i < ND; i++) dev_rdata[i*8 +: 8] = 8'($urandom());
        #1;
    endtask

    task automatic idle();
        set_in(16'h0100, 0, 0, 8'h00, 0, 8'h00, 7'h00);
    endtask

    task automatic tick();
        check_model();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push_key(input logic [7:0] code, input logic [6:0] asc);
        set_in(16'h0100, 0, 0, 8'h00, 1, code, asc);
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [15:0] a, input logic pop,
                               input logic [7:0] exp);
        set_in(a, 0, pop, 8'h00, 0, 8'h00, 7'h00);
        check(tag, data_i, exp);
        tick();
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        set_in(a, 1, 0, d, 0, 8'h00, 7'h00);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1;
        model_reset();
        address = 0; wren = 0; rden = 0; data_o = 0; data_o_sram = 0; dev_rdata = '0;
        ps2_hit = 0; ps2_data = 0; kb_ascii = 0;
        @(negedge clock);
        set_in(IOB + 16'h2, 0, 0, 8'h00, 0, 8'h00, 7'h00);
        check("rst_status", data_i, 8'h20);
        check("rst_bank", bank, 8'h00);
        check("rst_shift", kb_shift, 1'b0);
        @(negedge clock);
        reset = 0;
        idle();
        tick();

        // Banked window routing and unmapped bank
        write_reg(IOB, 8'h12);
        set_in(16'hF005, 1, 0, 8'hAA, 0, 8'h00, 7'h00);
        check("win_dev_we", dev_we, 2'b01);
        check("win_no_sram", data_w_sram, 1'b0);
        tick();
        write_reg(IOB, 8'h00);
        read_expect("win_sel0_ff", 16'hF005, 0, 8'hFF);

        // Make/break sequence and FIFO draining
        write_reg(IOB + 16'h3, 8'h03);
        push_key(8'h1C, 7'h61);
        push_key(8'hF0, 7'h00);
        push_key(8'h1C, 7'h61);
        read_expect("kb_status2", IOB + 16'h2, 0, 8'h02);
        read_expect("kb_make",    IOB + 16'h1, 1, 8'h61);
        read_expect("kb_status1", IOB + 16'h2, 0, 8'h01);
        read_expect("kb_break",   IOB + 16'h1, 1, 8'hE1);
        read_expect("kb_status0", IOB + 16'h2, 0, 8'h20);
        read_expect("kb_empty",   IOB + 16'h1, 1, 8'h00);

        // Shift tracking through make and break
        push_key(8'h12, 7'h00);
        check("shift_on", kb_shift, 1'b1);
        push_key(8'hF0, 7'h00);
        push_key(8'h12, 7'h00);
        check("shift_off", kb_shift, 1'b0);
        write_reg(IOB + 16'h3, 8'h01);

        // Fill past capacity: ninth byte lost, overflow sticky until cleared
        for (int i = 0; i < 8; i++) push_key(8'h1C, 7'(8'h30 + i));
        read_expect("full_status", IOB + 16'h2, 0, 8'h88);
        push_key(8'h1C, 7'h38);
        read_expect("ovf_status", IOB + 16'h2, 0, 8'hC8);
        write_reg(IOB + 16'h3, 8'h02);
        read_expect("ovf_cleared", IOB + 16'h2, 0, 8'h88);

        // Simultaneous push and pop on a full FIFO
        set_in(IOB + 16'h1, 0, 1, 8'h00, 1, 8'h1C, 7'h40);
        check("pp_head", data_i, 8'h30);
        tick();
        read_expect("pp_status", IOB + 16'h2, 0, 8'h88);
        for (int i = 1; i < 8; i++) read_expect("drain", IOB + 16'h1, 1, 8'(8'h30 + i));
        read_expect("drain_tail", IOB + 16'h1, 1, 8'h40);
        read_expect("drain_status", IOB + 16'h2, 0, 8'h20);

        // Cursor register write and readback, no SRAM write
        set_in(IOB + 16'hC, 1, 0, 8'h40, 0, 8'h00, 7'h00);
        check("cursx_no_sram", data_w_sram, 1'b0);
        tick();
        check("cursx_val", cursor_x, 8'h40);
        read_expect("cursx_read", IOB + 16'hC, 0, 8'h40);

        // Asynchronous reset between clock edges
        write_reg(IOB + 16'hC, 8'h05);
        for (int i = 0; i < 3; i++) push_key(8'h1C, 7'(8'h50 + i));
        read_expect("pre_rst_status", IOB + 16'h2, 0, 8'h03);
        set_in(IOB + 16'h2, 0, 0, 8'h00, 0, 8'h00, 7'h00);
        reset = 1;
        #1;
        model_reset();
        check("arst_cursx", cursor_x, 8'h00);
        check("arst_status", data_i, 8'h20);
        @(negedge clock);
        reset = 0;
        idle();
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          r  = $urandom_range(0, 15);
            int          k  = $urandom_range(0, 3);
            logic [15:0] a;
            logic [7:0]  code;
            case (r)
                0, 1:    a = IOB;
                2, 3, 4: a = IOB + 16'h1;
                5, 6:    a = IOB + 16'h2;
                7:       a = IOB + 16'h3;
                8:       a = IOB + 16'hC;
                9:       a = IOB + 16'hD;
                10:      a = IOB + 16'h18;
                11:      a = IOB + 16'h5;
                12, 13:  a = 16'($urandom_range(0, 32'hEFFF));
                default: a = WIN + 16'($urandom_range(0, 32'h0FFF));
            endcase
            case ($urandom_range(0, 7))
                0:       code = 8'hF0;
                1:       code = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
                default: code = 8'($urandom());
            endcase
            set_in(a, k == 1, k >= 2, 8'($urandom()), $urandom_range(0, 1) != 0, code,
                   7'($urandom()));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
